// File: rtl/board_scan_ctrl.sv
// board_scan_ctrl
//   Shares the framebuffer read port between the display reader (strict
//   priority) and a board sampler. After each completed frame the sampler
//   reads 188 sample points (18x10 playfield cells, then 2x4 preview cells)
//   into a shadow snapshot. A snapshot is offered to the AI engine only after
//   it has been identical for STABLE_SCANS consecutive scans.
//
//   Handshake: board_out is held stable while board_valid=1; a transfer
//   happens in any cycle with board_valid && board_ready, and board_valid
//   drops on the following cycle. board_ready without board_valid is ignored.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             1-cycle pulse: a new frame is complete (ignored unless idle)
//   vid_req/vid_addr  display read request and address
//   vid_dat_valid     fbdat this cycle answers a display request
//   fbrdaddress       framebuffer read address (display or sampler)
//   fbdat             framebuffer read data, RD_LAT cycles after its address
//   board_out         presented snapshot, bit 187 = row0/col0
//   board_valid       board_out holds an unconsumed snapshot
//   board_ready       AI engine accepts board_out
//   busy              scan, drain or evaluation in progress
module board_scan_ctrl #(
  parameter int RD_LAT       = 1,
  parameter int STABLE_SCANS = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         vid_req,
  input  logic [14:0]  vid_addr,
  output logic         vid_dat_valid,
  output logic [14:0]  fbrdaddress,
  input  logic [1:0]   fbdat,
  output logic [187:0] board_out,
  output logic         board_valid,
  input  logic         board_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, EVAL} state_t;

  localparam logic [3:0] STABLE_N = 4'(STABLE_SCANS);

  state_t        state;
  logic [7:0]    k;
  logic [3:0]    col;
  logic [14:0]   scan_addr;

  // Tag pipe: one entry per cycle of read latency; the tail lines up with fbdat.
  logic [RD_LAT-1:0] p_disp;
  logic [RD_LAT-1:0] p_scan;
  logic [7:0]        p_idx [RD_LAT];

  logic [187:0]  shadow;
  logic [187:0]  last_scan;
  logic [187:0]  last_pres;
  logic [3:0]    stable_cnt;
  logic          pres_once;

  logic          issue;
  logic          accept;
  logic          valid_eff;
  logic [187:0]  pres_eff;
  logic [3:0]    cnt_next;
  logic          present;

  assign fbrdaddress   = vid_req ? vid_addr : scan_addr;
  assign issue         = (state == SCAN) && !vid_req;
  assign vid_dat_valid = p_disp[RD_LAT-1];
  assign busy          = (state != IDLE);
  assign accept        = board_valid && board_ready;

  // An accept in the EVAL cycle is applied before the presentation decision.
  assign valid_eff = board_valid && !accept;
  assign pres_eff  = accept ? board_out : last_pres;

  always_comb begin
    cnt_next = 4'd1;
    if (shadow == last_scan)
      cnt_next = (stable_cnt == STABLE_N) ? STABLE_N : stable_cnt + 4'd1;
    present = (cnt_next == STABLE_N) && ((shadow != pres_eff) || !pres_once) && !valid_eff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      k           <= 8'd0;
      col         <= 4'd0;
      scan_addr   <= 15'd0;
      p_disp      <= '0;
      p_scan      <= '0;
      for (int i = 0; i < RD_LAT; i++) p_idx[i] <= 8'd0;
      shadow      <= '0;
      last_scan   <= '0;
      last_pres   <= '0;
      stable_cnt  <= 4'd0;
      pres_once   <= 1'b0;
      board_out   <= '0;
      board_valid <= 1'b0;
    end else begin
      p_disp[0] <= vid_req;
      p_scan[0] <= issue;
      p_idx[0]  <= k;
      for (int i = 1; i < RD_LAT; i++) begin
        p_disp[i] <= p_disp[i-1];
        p_scan[i] <= p_scan[i-1];
        p_idx[i]  <= p_idx[i-1];
      end

      if (p_scan[RD_LAT-1])
        shadow[8'd187 - p_idx[RD_LAT-1]] <= (fbdat != 2'b00);

      if (accept) begin
        board_valid <= 1'b0;
        last_pres   <= board_out;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            k         <= 8'd0;
            col       <= 4'd0;
            scan_addr <= 15'd16;
          end
        end
        SCAN: begin
          if (issue) begin
            k <= k + 8'd1;
            // Address walk: +8 per column, +1280-72 per row, then jump to
            // the two preview rows.
            if (k == 8'd179) begin
              scan_addr <= 15'd18040;
            end else if (k == 8'd183) begin
              scan_addr <= 15'd19320;
            end else if ((k < 8'd180) && (col == 4'd9)) begin
              scan_addr <= scan_addr + 15'd1208;
              col       <= 4'd0;
            end else begin
              scan_addr <= scan_addr + 15'd8;
              col       <= col + 4'd1;
            end
            if (k == 8'd187) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (p_scan == '0) state <= EVAL;
        end
        EVAL: begin
          stable_cnt <= cnt_next;
          last_scan  <= shadow;
          if (present) begin
            board_out   <= shadow;
            board_valid <= 1'b1;
            pres_once   <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
